// File: rtl/drum_seq_pkg.sv
// ---------------------------------------------------------------------------
// drum_seq_pkg
// Shared types and constants for the step sequencer and its voice gates.
//   NUM_STEPS_DEF / NUM_VOICES_DEF : default pattern geometry
//   TEMPO_MIN                      : shortest step, leaves room for the
//                                    one-cycle retrigger gap
//   step_t, pattern_row_t          : step index / pattern row at defaults
//   seq_state_e                    : sequencer FSM states
//   clamp_tempo()                  : applies TEMPO_MIN to a tempo divider
// ---------------------------------------------------------------------------
package drum_seq_pkg;

  localparam int NUM_STEPS_DEF  = 16;
  localparam int NUM_VOICES_DEF = 4;
  localparam int TEMPO_MIN      = 2;

  typedef logic [$clog2(NUM_STEPS_DEF)-1:0] step_t;
  typedef logic [NUM_STEPS_DEF-1:0]         pattern_row_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  // A step of 1 cycle could not hold the low gap plus the re-raised enable.
  function automatic logic [15:0] clamp_tempo(input logic [15:0] div);
    return (div < 16'(TEMPO_MIN)) ? 16'(TEMPO_MIN) : div;
  endfunction

endpackage

// File: rtl/voice_gate.sv
// ---------------------------------------------------------------------------
// voice_gate
// Enable generator for one sample player. A hit raises voice_en for GATE_LEN
// cycles; a hit on an already-high gate drops it for one cycle first so the
// player rewinds, then raises it for a fresh GATE_LEN. run=0 cuts the gate.
// Ports:
//   clk       sample-rate clock
//   rst_n     synchronous active-low reset
//   run       0 = sequencer stopped, gate forced low
//   fire      hit for this voice on the current step edge
//   voice_en  enable to the sample player
// ---------------------------------------------------------------------------
module voice_gate
  import drum_seq_pkg::*;
#(
  parameter int GATE_LEN = 4000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic fire,
  output logic voice_en
);

  localparam int            CW   = (GATE_LEN > 1) ? $clog2(GATE_LEN) : 1;
  localparam logic [CW-1:0] LOAD = CW'(GATE_LEN - 1);

  logic [CW-1:0] cnt_q;
  logic          gap_q;

  // cnt_q counts remaining high cycles after the current one, so the gate
  // drops on the edge where it reads zero: GATE_LEN high cycles in total.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      voice_en <= 1'b0;
      cnt_q    <= '0;
      gap_q    <= 1'b0;
    end else if (!run) begin
      voice_en <= 1'b0;
      gap_q    <= 1'b0;
    end else if (fire) begin
      if (voice_en) begin
        // retrigger: hold low one cycle, reload when re-raised
        voice_en <= 1'b0;
        gap_q    <= 1'b1;
      end else begin
        voice_en <= 1'b1;
        cnt_q    <= LOAD;
        gap_q    <= 1'b0;
      end
    end else if (gap_q) begin
      voice_en <= 1'b1;
      cnt_q    <= LOAD;
      gap_q    <= 1'b0;
    end else if (voice_en) begin
      if (cnt_q == '0) begin
        voice_en <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// ---------------------------------------------------------------------------
// step_sequencer
// Pattern-driven trigger generator feeding per-voice sample players.
// Owns tempo, step position and the pattern RAM; per-voice gating lives in
// voice_gate.
// Ports:
//   clk          sample-rate clock
//   rst_n        synchronous active-low reset
//   run          level, 1 = play, 0 = stop
//   tempo_div    cycles per step (values below 2 act as 2)
//   pat_we       pattern row write strobe
//   pat_voice    row to write
//   pat_data     row contents, bit s = hit on step s
//   voice_en     enable to each sample player
//   step_idx     current step
//   step_strobe  one-cycle pulse on each step boundary and on start
//
// state | meaning
// IDLE  | stopped; step 0, gates low, waiting for run
// RUN   | counting ticks, advancing and firing steps
// ---------------------------------------------------------------------------
module step_sequencer
  import drum_seq_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int NUM_STEPS  = NUM_STEPS_DEF,
  parameter int GATE_LEN   = 4000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic [15:0]                   tempo_div,
  input  logic                          pat_we,
  input  logic [$clog2(NUM_VOICES)-1:0] pat_voice,
  input  logic [NUM_STEPS-1:0]          pat_data,
  output logic [NUM_VOICES-1:0]         voice_en,
  output logic [$clog2(NUM_STEPS)-1:0]  step_idx,
  output logic                          step_strobe
);

  localparam int SW = $clog2(NUM_STEPS);
  localparam int VW = $clog2(NUM_VOICES);

  seq_state_e           state_q, state_d;
  logic [15:0]          tick_q, tick_d;
  logic [15:0]          tempo_q, tempo_d;
  logic [SW-1:0]        step_q, step_d;
  logic [SW-1:0]        fire_idx;
  logic                 fire_step;
  logic [NUM_STEPS-1:0] pattern [NUM_VOICES];
  logic [NUM_VOICES-1:0] fire_voice;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    tempo_d   = tempo_q;
    step_d    = step_q;
    fire_step = 1'b0;
    fire_idx  = '0;
    case (state_q)
      IDLE: begin
        step_d = '0;
        tick_d = '0;
        if (run) begin
          state_d   = RUN;
          tempo_d   = clamp_tempo(tempo_div);
          fire_step = 1'b1;
        end
      end
      RUN: begin
        // stop wins over a coinciding boundary: no fire on the stop edge
        if (!run) begin
          state_d = IDLE;
          step_d  = '0;
          tick_d  = '0;
        end else if (tick_q == tempo_q - 16'd1) begin
          tick_d    = '0;
          step_d    = step_q + SW'(1);
          tempo_d   = clamp_tempo(tempo_div);
          fire_step = 1'b1;
          fire_idx  = step_d;
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      tempo_q     <= 16'(TEMPO_MIN);
      step_q      <= '0;
      step_strobe <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      tempo_q     <= tempo_d;
      step_q      <= step_d;
      step_strobe <= fire_step;
    end
  end

  // Rows are read combinationally for the firing edge, so a write on that
  // same edge only affects later steps. Out-of-range rows never match.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!rst_n) begin
        pattern[v] <= '0;
      end else if (pat_we && (pat_voice == VW'(v))) begin
        pattern[v] <= pat_data;
      end
    end
  end

  assign step_idx = step_q;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    assign fire_voice[v] = fire_step & pattern[v][fire_idx];

    voice_gate #(
      .GATE_LEN (GATE_LEN)
    ) u_gate (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .fire     (fire_voice[v]),
      .voice_en (voice_en[v])
    );
  end

endmodule

// File: tb/tb_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_step_sequencer
// Two sequencers (GATE_LEN 5 and 12) share one stimulus stream. A behavioural
// model predicts each edge's outputs into a scoreboard queue; directed
// sequences and a vector table add targeted checks.
// ---------------------------------------------------------------------------
module tb_step_sequencer;

  localparam int NV = 4;
  localparam int NS = 16;

  logic        clk = 1'b0;
  logic        rst_n, run, pat_we;
  logic [15:0] tempo_div;
  logic [1:0]  pat_voice;
  logic [15:0] pat_data;
  logic [3:0]  en5, en12;
  logic [3:0]  step5, step12;
  logic        strb5, strb12;

  always #5 clk = ~clk;

  step_sequencer #(.NUM_VOICES(NV), .NUM_STEPS(NS), .GATE_LEN(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .run(run), .tempo_div(tempo_div),
    .pat_we(pat_we), .pat_voice(pat_voice), .pat_data(pat_data),
    .voice_en(en5), .step_idx(step5), .step_strobe(strb5)
  );

  step_sequencer #(.NUM_VOICES(NV), .NUM_STEPS(NS), .GATE_LEN(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .run(run), .tempo_div(tempo_div),
    .pat_we(pat_we), .pat_voice(pat_voice), .pat_data(pat_data),
    .voice_en(en12), .step_idx(step12), .step_strobe(strb12)
  );

  typedef struct {
    logic [3:0] en5;
    logic [3:0] en12;
    logic [3:0] step;
    logic       strobe;
  } exp_t;

  typedef struct {
    logic [3:0][15:0] rows;
    int               tempo;
    int               cycles;
    int               exp_strobes;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // model state
  bit          m_run;
  int          m_tick, m_tq, m_step;
  logic [15:0] m_pat [NV];
  int          m_rem [2][NV];
  bit          m_gap [2][NV];
  bit          m_strb;

  function automatic int gl(input int g);
    return (g == 0) ? 5 : 12;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_step();
    bit fire;
    int fidx;
    int t;
    fire = 0;
    fidx = 0;
    if (!rst_n) begin
      m_run = 0; m_tick = 0; m_tq = 2; m_step = 0; m_strb = 0;
      for (int v = 0; v < NV; v++) begin
        m_pat[v] = '0;
        for (int g = 0; g < 2; g++) begin
          m_rem[g][v] = 0;
          m_gap[g][v] = 0;
        end
      end
      return;
    end
    t = (tempo_div < 2) ? 2 : int'(tempo_div);
    if (!m_run) begin
      if (run) begin
        m_run = 1; m_tick = 0; m_tq = t; m_step = 0; fire = 1; fidx = 0;
      end
    end else if (!run) begin
      m_run = 0; m_tick = 0; m_step = 0;
    end else if (m_tick + 1 == m_tq) begin
      m_tick = 0; m_step = (m_step + 1) % NS; m_tq = t; fire = 1; fidx = m_step;
    end else begin
      m_tick++;
    end
    m_strb = fire;
    for (int g = 0; g < 2; g++) begin
      for (int v = 0; v < NV; v++) begin
        if (!run) begin
          m_rem[g][v] = 0;
          m_gap[g][v] = 0;
        end else if (fire && m_pat[v][fidx]) begin
          if (m_rem[g][v] > 0) begin
            m_rem[g][v] = 0;
            m_gap[g][v] = 1;
          end else begin
            m_rem[g][v] = gl(g);
            m_gap[g][v] = 0;
          end
        end else if (m_gap[g][v]) begin
          m_gap[g][v] = 0;
          m_rem[g][v] = gl(g);
        end else if (m_rem[g][v] > 0) begin
          m_rem[g][v]--;
        end
      end
    end
    if (pat_we) m_pat[pat_voice] = pat_data;
  endtask

  // One clock: predict, push, clock, sample, pop, compare.
  task automatic cycle();
    exp_t e;
    model_step();
    for (int v = 0; v < NV; v++) begin
      e.en5[v]  = (m_rem[0][v] > 0);
      e.en12[v] = (m_rem[1][v] > 0);
    end
    e.step   = 4'(m_step);
    e.strobe = m_strb;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sb_en_g5", en5, e.en5);
    chk("sb_en_g12", en12, e.en12);
    chk("sb_step_g5", step5, e.step);
    chk("sb_step_g12", step12, e.step);
    chk("sb_strobe_g5", strb5, e.strobe);
    chk("sb_strobe_g12", strb12, e.strobe);
  endtask

  task automatic write_row(input logic [1:0] v, input logic [15:0] d);
    pat_we = 1'b1; pat_voice = v; pat_data = d;
    cycle();
    pat_we = 1'b0;
  endtask

  task automatic stop(input int n);
    run = 1'b0;
    repeat (n) cycle();
  endtask

  vec_t        tbl [4];
  int          hi, sc;
  logic [3:0]  any;
  logic [23:0] tr, tr_exp;
  logic [31:0] sv, sv_exp;

  initial begin
    rst_n = 1'b0; run = 1'b0; pat_we = 1'b0; tempo_div = 16'd8;
    pat_voice = '0; pat_data = '0;

    tbl[0] = '{rows: {16'h8000, 16'hFFFF, 16'h0101, 16'h1111}, tempo: 3, cycles: 60, exp_strobes: 20};
    tbl[1] = '{rows: {16'hF0F0, 16'h0F0F, 16'h5555, 16'hAAAA}, tempo: 2, cycles: 40, exp_strobes: 20};
    tbl[2] = '{rows: {16'h8421, 16'h1248, 16'h0000, 16'hFFFF}, tempo: 1, cycles: 33, exp_strobes: 17};
    tbl[3] = '{rows: {16'h0000, 16'hC003, 16'h8001, 16'h0001}, tempo: 7, cycles: 50, exp_strobes: 8};

    // 1. reset dominates run and writes
    run = 1'b1; pat_we = 1'b1; pat_voice = 2'd1; pat_data = 16'hFFFF;
    repeat (3) cycle();
    chk("rst_en", en5, 0);
    chk("rst_step", step5, 0);
    chk("rst_strobe", strb5, 0);
    rst_n = 1'b1; pat_we = 1'b0; tempo_div = 16'd2;
    any = '0;
    repeat (32) begin cycle(); any |= en5 | en12; end
    chk("rows_clear_after_rst", any, 0);
    stop(2);

    // 2. single hit, tempo 8, full bar and wrap
    tempo_div = 16'd8;
    write_row(2'd0, 16'h0001);
    run = 1'b1; hi = 0; sc = 0;
    for (int k = 0; k <= 128; k++) begin
      cycle();
      if (k == 0) chk("start_strobe", strb5, 1);
      if (k < 10) hi += int'(en5[0]);
      if (k < 128) sc += int'(strb5);
      if (k == 127) chk("step_before_wrap", step5, 15);
    end
    chk("gate5_len", hi, 5);
    chk("strobes_per_bar", sc, 16);
    chk("step_wrap", step5, 0);
    chk("refire_bar2", en5[0], 1);
    stop(2);

    // 3. retrigger gap on the 12-cycle gate
    write_row(2'd0, 16'h0000);
    write_row(2'd1, 16'h0003);
    run = 1'b1;
    for (int k = 0; k < 24; k++) begin
      cycle();
      tr[k]     = en12[1];
      tr_exp[k] = (k < 8) || (k >= 9 && k <= 20);
    end
    chk("retrig_trace", tr, tr_exp);
    stop(2);

    // 4. stop mid-gate, then restart
    write_row(2'd1, 16'h0000);
    write_row(2'd0, 16'h0010);
    run = 1'b1;
    repeat (35) cycle();
    chk("gate_before_stop", en5[0], 1);
    chk("step_before_stop", step5, 4);
    run = 1'b0;
    cycle();
    chk("stop_en", en5, 0);
    chk("stop_en12", en12, 0);
    chk("stop_step", step5, 0);
    chk("stop_strobe", strb5, 0);
    cycle();
    write_row(2'd0, 16'h0011);
    run = 1'b1;
    cycle();
    chk("restart_strobe", strb5, 1);
    chk("restart_step", step5, 0);
    chk("restart_en", en5[0], 1);
    stop(2);

    // 5. tempo latched only at boundaries, clamp of 0 to 2
    write_row(2'd0, 16'h0000);
    tempo_div = 16'd8; run = 1'b1;
    for (int k = 0; k < 32; k++) begin
      cycle();
      sv[k] = strb5;
      if (k == 1) tempo_div = 16'd4;
      if (k == 21) tempo_div = 16'd0;
    end
    sv_exp = '0;
    sv_exp[0] = 1'b1; sv_exp[8] = 1'b1; sv_exp[12] = 1'b1; sv_exp[16] = 1'b1;
    sv_exp[20] = 1'b1; sv_exp[24] = 1'b1; sv_exp[26] = 1'b1; sv_exp[28] = 1'b1;
    sv_exp[30] = 1'b1;
    chk("tempo_strobes", sv, sv_exp);
    stop(2);

    // 6. write on the firing edge uses the old row; reset mid-gate
    tempo_div = 16'd8; run = 1'b1;
    for (int k = 0; k <= 146; k++) begin
      cycle();
      if (k == 15) begin pat_we = 1'b1; pat_voice = 2'd2; pat_data = 16'h0004; end
      if (k == 16) begin pat_we = 1'b0; chk("write_on_fire_old_row", en5[2], 0); end
      if (k == 17) chk("write_on_fire_still_low", en5[2], 0);
      if (k == 144) chk("write_next_bar", en5[2], 1);
    end
    rst_n = 1'b0;
    cycle();
    chk("midrst_en", en5, 0);
    chk("midrst_en12", en12, 0);
    chk("midrst_step", step5, 0);
    chk("midrst_strobe", strb5, 0);
    rst_n = 1'b1; tempo_div = 16'd2;
    any = '0;
    repeat (40) begin cycle(); any |= en5 | en12; end
    chk("rows_clear_after_midrst", any, 0);
    stop(2);

    // vector table: mixed patterns and tempos, every edge checked by model
    for (int i = 0; i < 4; i++) begin
      for (int v = 0; v < NV; v++) write_row(2'(v), tbl[i].rows[v]);
      tempo_div = 16'(tbl[i].tempo);
      run = 1'b1; sc = 0;
      repeat (tbl[i].cycles) begin cycle(); sc += int'(strb5); end
      chk("tbl_strobes", sc, tbl[i].exp_strobes);
      stop(3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
